// File: rtl/eth_idma_launch_pkg.sv
// eth_idma_launch_pkg: shared types and defaults for the iDMA request launcher
package eth_idma_launch_pkg;
  localparam int unsigned DefaultNumOutstanding = 4;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} launch_state_e;
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
  } idma_req_def_t;
  typedef struct packed {
    logic       error;
    logic [7:0] pld;
  } idma_rsp_def_t;
endpackage

// File: rtl/eth_idma_req_launcher.sv
// eth_idma_req_launcher: turns launch pulses into held iDMA requests and tracks responses
module eth_idma_req_launcher
  import eth_idma_launch_pkg::*;
#(
  parameter int unsigned NumOutstanding = DefaultNumOutstanding,
  parameter int unsigned DoneCntWidth = 8,
  parameter type idma_req_t = idma_req_def_t,
  parameter type idma_rsp_t = idma_rsp_def_t,
  localparam idma_rsp_t RspZero = '0,
  localparam int unsigned PldWidth = $bits(RspZero.pld),
  localparam int unsigned OutWidth = $clog2(NumOutstanding + 1)
)(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  idma_req_t               desc_i,
  input  logic                    launch_i,
  output logic                    launch_ack_o,
  output logic                    launch_rej_o,
  output idma_req_t               idma_req_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  input  idma_rsp_t               idma_rsp_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  output logic [OutWidth-1:0]     outstanding_o,
  output logic [DoneCntWidth-1:0] done_cnt_o,
  input  logic                    done_ack_i,
  output logic                    err_o,
  output logic [PldWidth-1:0]     err_pld_o,
  input  logic                    err_clr_i,
  input  logic                    irq_en_i,
  output logic                    irq_o,
  output logic                    busy_o
);
  launch_state_e           state_q, state_d;
  idma_req_t               hold_q;
  logic [OutWidth-1:0]     out_q;
  logic [DoneCntWidth-1:0] done_q;
  logic [PldWidth-1:0]     pld_q;
  logic                    ack_q, rej_q, err_q;
  logic                    launch_ok, req_hs, rsp_hs, err_set, done_inc, done_dec;

  assign launch_ok = launch_i & (state_q == IDLE) & (out_q < OutWidth'(NumOutstanding));
  assign req_hs    = req_valid_o & req_ready_i;
  assign rsp_hs    = rsp_valid_i & rsp_ready_o;
  // a clear in the same cycle as a new error must not block its capture
  assign err_set   = rsp_hs & idma_rsp_i.error & (~err_q | err_clr_i);
  assign done_inc  = rsp_hs & ~(done_ack_i & (done_q != '0));
  assign done_dec  = done_ack_i & ~rsp_hs & (done_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q == IDLE) ? (launch_ok ? REQ : IDLE) : (req_ready_i ? IDLE : REQ);
  end

  always_comb begin
    req_valid_o   = (state_q == REQ);
    idma_req_o    = hold_q;
    launch_ack_o  = ack_q;
    launch_rej_o  = rej_q;
    outstanding_o = out_q;
    rsp_ready_o   = (out_q != '0);
    done_cnt_o    = done_q;
    err_o         = err_q;
    err_pld_o     = pld_q;
    irq_o         = irq_en_i & ((done_q != '0) | err_q);
    busy_o        = (state_q != IDLE) | (out_q != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      ack_q  <= 1'b0;
      rej_q  <= 1'b0;
      out_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      pld_q  <= '0;
    end else begin
      ack_q <= launch_ok;
      rej_q <= launch_i & ~launch_ok;
      if (launch_ok) hold_q <= desc_i;
      out_q <= out_q + OutWidth'(req_hs) - OutWidth'(rsp_hs);
      if (done_inc) done_q <= done_q + DoneCntWidth'(done_q != '1);
      else if (done_dec) done_q <= done_q - DoneCntWidth'(1);
      err_q <= err_set | (err_q & ~err_clr_i);
      if (err_set) pld_q <= idma_rsp_i.pld;
      else if (err_clr_i) pld_q <= '0;
    end
  end
endmodule

// File: tb/tb_eth_idma_req_launcher.sv
// tb_eth_idma_req_launcher: vector table, corner sequences and random run against a model
module tb_eth_idma_req_launcher;
  import eth_idma_launch_pkg::*;

  logic clk = 1'b0, rst_ni = 1'b1;
  idma_req_def_t desc, idma_req;
  idma_rsp_def_t rsp;
  logic launch, ack, rej, valid, rdy, rsp_v, rsp_rdy, done_ack, err, err_clr, irq_en, irq, busy;
  logic [2:0] outst;
  logic [1:0] dc;
  logic [7:0] pld;
  int total = 0, bad = 0;

  eth_idma_req_launcher #(.NumOutstanding(4), .DoneCntWidth(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .desc_i(desc), .launch_i(launch),
    .launch_ack_o(ack), .launch_rej_o(rej), .idma_req_o(idma_req),
    .req_valid_o(valid), .req_ready_i(rdy), .idma_rsp_i(rsp), .rsp_valid_i(rsp_v),
    .rsp_ready_o(rsp_rdy), .outstanding_o(outst), .done_cnt_o(dc), .done_ack_i(done_ack),
    .err_o(err), .err_pld_o(pld), .err_clr_i(err_clr), .irq_en_i(irq_en), .irq_o(irq),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic launch, rdy, rsp_v, rsp_e;
    logic [7:0] pld;
    logic dack, clr, irq_en;
    logic e_ack, e_rej, e_valid;
    int e_out, e_dc;
    logic e_err;
    logic [7:0] e_pld;
    logic e_irq, e_busy;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    launch = 0; rdy = 0; rsp_v = 0; rsp = '0; done_ack = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_ni = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
  endtask

  task automatic chk_all(input string n, input logic e_ack, e_rej, e_valid, input int e_out, e_dc,
                         input logic e_err, input logic [7:0] e_pld, input logic e_irq, e_busy);
    chk({n, ".ack"}, ack, e_ack);
    chk({n, ".rej"}, rej, e_rej);
    chk({n, ".valid"}, valid, e_valid);
    chk({n, ".out"}, outst, 80'(e_out));
    chk({n, ".rsp_rdy"}, rsp_rdy, e_out != 0);
    chk({n, ".dc"}, dc, 80'(e_dc));
    chk({n, ".err"}, err, e_err);
    chk({n, ".pld"}, pld, e_pld);
    chk({n, ".irq"}, irq, e_irq);
    chk({n, ".busy"}, busy, e_busy);
  endtask

  task automatic issue(input idma_req_def_t d);
    desc = d; launch = 1; step(); launch = 0;
    rdy = 1; step(); rdy = 0;
  endtask

  task automatic respond(input logic e, input logic [7:0] p);
    rsp_v = 1; rsp = '{error: e, pld: p}; step(); rsp_v = 0; rsp = '0;
  endtask

  idma_req_def_t d0, d1, d2;
  // reference model state
  logic m_pend, m_ack, m_rej, m_err, acc, rhs, shs;
  idma_req_def_t m_hold;
  int m_out, m_dc;
  logic [7:0] m_pld;

  initial begin
    d0 = '{32'h1000_0000, 32'h2000_0000, 16'h0040};
    d1 = '{32'hdead_beef, 32'hcafe_f00d, 16'h1234};
    d2 = '{32'h0bad_cafe, 32'h1357_9bdf, 16'h0100};
    vt[0]  = '{1,0,0,0,8'h00,0,0,1, 1,0,1,0,0,0,8'h00,0,1};
    vt[1]  = '{1,0,0,0,8'h00,0,0,1, 0,1,1,0,0,0,8'h00,0,1};
    vt[2]  = '{0,1,0,0,8'h00,0,0,1, 0,0,0,1,0,0,8'h00,0,1};
    vt[3]  = '{0,0,1,1,8'hAA,0,0,1, 0,0,0,0,1,1,8'hAA,1,0};
    vt[4]  = '{0,0,0,0,8'h00,1,0,1, 0,0,0,0,0,1,8'hAA,1,0};
    vt[5]  = '{0,0,0,0,8'h00,0,1,1, 0,0,0,0,0,0,8'h00,0,0};
    vt[6]  = '{1,0,0,0,8'h00,0,0,0, 1,0,1,0,0,0,8'h00,0,1};
    vt[7]  = '{1,1,0,0,8'h00,0,0,1, 0,1,0,1,0,0,8'h00,0,1};
    vt[8]  = '{0,0,1,0,8'h33,1,0,1, 0,0,0,0,1,0,8'h00,1,0};
    vt[9]  = '{0,0,1,1,8'h44,0,0,1, 0,0,0,0,1,0,8'h00,1,0};
    vt[10] = '{0,0,0,0,8'h00,1,0,0, 0,0,0,0,0,0,8'h00,0,0};
    desc = d0; irq_en = 1;
    clr_in();
    #1 do_reset();
    chk_all("reset", 0,0,0,0,0,0,8'h00,0,0);
    chk("reset.req", idma_req, 80'(0));

    for (int i = 0; i < 11; i++) begin
      launch = vt[i].launch; rdy = vt[i].rdy; rsp_v = vt[i].rsp_v;
      rsp = '{error: vt[i].rsp_e, pld: vt[i].pld};
      done_ack = vt[i].dack; err_clr = vt[i].clr; irq_en = vt[i].irq_en;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_rej, vt[i].e_valid, vt[i].e_out,
              vt[i].e_dc, vt[i].e_err, vt[i].e_pld, vt[i].e_irq, vt[i].e_busy);
      if (vt[i].e_valid) chk($sformatf("vec%0d.req", i), idma_req, d0);
    end
    clr_in(); irq_en = 1;

    // single transfer, ready three cycles late, descriptor changes after launch
    do_reset();
    desc = d1; launch = 1; step(); launch = 0; desc = d2;
    chk("single.ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("single.valid%0d", i), valid, 1);
      chk($sformatf("single.req%0d", i), idma_req, d1);
      rdy = (i == 3);
      step();
    end
    rdy = 0;
    chk("single.valid_after", valid, 0);
    chk("single.out1", outst, 1);
    respond(0, 8'h11);
    chk("single.out0", outst, 0);
    chk("single.dc1", dc, 1);
    chk("single.irq1", irq, 1);
    done_ack = 1; step(); done_ack = 0;
    chk("single.irq0", irq, 0);
    chk("single.dc0", dc, 0);

    // fill, reject when full, then saturate the 2-bit done counter
    do_reset();
    for (int i = 0; i < 4; i++) begin
      desc = d0 ^ 80'(i); launch = 1; step(); launch = 0;
      chk($sformatf("fill.ack%0d", i), ack, 1);
      rdy = 1; step(); rdy = 0;
    end
    chk("fill.out4", outst, 4);
    launch = 1; step(); launch = 0;
    chk("fill.rej", rej, 1);
    chk("fill.noack", ack, 0);
    chk("fill.novalid", valid, 0);
    step();
    chk("fill.novalid2", valid, 0);
    for (int i = 0; i < 4; i++) respond(0, 8'h00);
    issue(d1);
    respond(0, 8'h00);
    chk("sat.dc3", dc, 3);
    chk("sat.out0", outst, 0);
    repeat (3) begin done_ack = 1; step(); end
    done_ack = 0;
    chk("sat.dc0", dc, 0);
    done_ack = 1; step(); done_ack = 0;
    chk("sat.dc_floor", dc, 0);

    // first error sticks, clear coinciding with a new error
    do_reset();
    repeat (3) issue(d0);
    respond(1, 8'hA1);
    respond(1, 8'hB2);
    chk("err.flag", err, 1);
    chk("err.pldA", pld, 8'hA1);
    err_clr = 1; respond(1, 8'hC3); err_clr = 0;
    chk("err.clr_lose", err, 1);
    chk("err.pldC", pld, 8'hC3);
    err_clr = 1; step(); err_clr = 0;
    chk("err.cleared", err, 0);
    chk("err.pld0", pld, 0);

    // simultaneous handshakes
    do_reset();
    repeat (2) issue(d0);
    desc = d1; launch = 1; step(); launch = 0;
    rdy = 1; rsp_v = 1; step(); rdy = 0; rsp_v = 0;
    chk("sim.out2", outst, 2);
    chk("sim.dc1", dc, 1);
    rsp_v = 1; done_ack = 1; step(); rsp_v = 0; done_ack = 0;
    chk("sim.dc_hold", dc, 1);
    chk("sim.out1", outst, 1);

    // asynchronous reset while a request is held
    do_reset();
    repeat (2) issue(d0);
    respond(1, 8'h5A);
    desc = d1; launch = 1; step(); launch = 0;
    chk("rst.valid_pre", valid, 1);
    rst_ni = 0;
    #1;
    chk_all("rst.async", 0,0,0,0,0,0,8'h00,0,0);
    chk("rst.req", idma_req, 80'(0));
    #10 rst_ni = 1;
    rsp_v = 1; step(); rsp_v = 0;
    chk("rst.stale_rsp_out", outst, 0);
    chk("rst.stale_rsp_dc", dc, 0);
    desc = d2; launch = 1; step(); launch = 0;
    chk("rst.ack", ack, 1);
    chk("rst.valid", valid, 1);
    chk("rst.req_new", idma_req, d2);

    // random traffic against a transaction-level model
    do_reset();
    m_pend = 0; m_hold = '0; m_out = 0; m_dc = 0; m_err = 0; m_pld = 0;
    for (int c = 0; c < 500; c++) begin
      launch = ($urandom_range(2) == 0); rdy = $urandom_range(1); rsp_v = $urandom_range(1);
      rsp = '{error: ($urandom_range(3) == 0), pld: 8'($urandom)};
      done_ack = ($urandom_range(3) == 0); err_clr = ($urandom_range(7) == 0);
      irq_en = $urandom_range(1); desc = {$urandom, $urandom, 16'($urandom)};
      acc = launch && !m_pend && m_out < 4;
      m_ack = acc; m_rej = launch && !acc;
      rhs = m_pend && rdy;
      shs = rsp_v && m_out > 0;
      m_out = m_out + int'(rhs) - int'(shs);
      if (shs && !(done_ack && m_dc > 0)) m_dc = (m_dc < 3) ? m_dc + 1 : 3;
      else if (done_ack && !shs && m_dc > 0) m_dc = m_dc - 1;
      if (shs && rsp.error && (!m_err || err_clr)) begin m_err = 1; m_pld = rsp.pld; end
      else if (err_clr) begin m_err = 0; m_pld = 0; end
      if (acc) begin m_pend = 1; m_hold = desc; end
      else if (rhs) m_pend = 0;
      step();
      chk_all($sformatf("rnd%0d", c), m_ack, m_rej, m_pend, m_out, m_dc, m_err, m_pld,
              irq_en && (m_dc != 0 || m_err), m_pend || m_out != 0);
      if (m_pend) chk($sformatf("rnd%0d.req", c), idma_req, m_hold);
    end
    clr_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
